zero_skip_scheduler: RTL

Sequencing controller in front of a PE/MAC column. Accepts a fixed-length burst of FP16 operand pairs and applies the team's zero-detection rule to each pair. Near-zero pairs are dropped without consuming a MAC slot; all other pairs go out on a registered valid/ready stream. At burst end it pulses `done` and reports how many pairs were skipped and issued.

---
 rtl/zero_skip_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/zero_skip_scheduler.sv
// Zero-skipping sequencer in front of a PE/MAC column: drops near-zero FP16 pairs, issues the rest.
// Optional skip/issue statistics are built only when ZERO_SKIP_STATS_EN is defined.
module zero_skip_scheduler #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int WIDTH_T = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    input  logic [WIDTH_T-1:0] thres,
    input  logic               in_valid,
    input  logic [WIDTH_A-1:0] in_a,
    input  logic [WIDTH_B-1:0] in_b,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WIDTH_A-1:0] out_a,
    output logic [WIDTH_B-1:0] out_b,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   skip_cnt,
    output logic [CNT_W-1:0]   issue_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   rem;
    logic [WIDTH_T-1:0] thr;
    logic               vld_p1;
    logic [WIDTH_A-1:0] a_p1;
    logic [WIDTH_B-1:0] b_p1;

    logic accept, pair_zero, load, drain_hs, burst_go;

    // Magnitude-zero or exponent below threshold on either operand; sign bit is ignored.
    function automatic logic is_zero(input logic [14:0] a, input logic [14:0] b,
                                     input logic [WIDTH_T-1:0] t);
        logic [4:0] t5;
        t5 = 5'(t);
        return (a == 15'd0) || (b == 15'd0) || (a[14:10] < t5) || (b[14:10] < t5);
    endfunction

    assign in_ready  = (state == S_RUN) && (rem != '0) && (!vld_p1 || out_ready);
    assign accept    = in_valid && in_ready;
    assign pair_zero = is_zero(in_a[14:0], in_b[14:0], thr);
    assign load      = accept && !pair_zero;
    assign drain_hs  = vld_p1 && out_ready;
    assign burst_go  = (state == S_IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (accept && rem == CNT_W'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (!vld_p1 || out_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: accepted non-zero pair enters the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rem    <= '0;
            thr    <= '0;
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
        end else begin
            state <= state_nxt;
            if (burst_go) begin
                rem <= len;
                thr <= thres;
            end else if (accept) begin
                rem <= rem - 1'b1;
            end
            if (load) begin
                vld_p1 <= 1'b1;
                a_p1   <= in_a;
                b_p1   <= in_b;
            end else if (drain_hs) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_a     = a_p1;
    assign out_b     = b_p1;
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

`ifdef ZERO_SKIP_STATS_EN
    logic [CNT_W-1:0] skip_q, issue_q;

    always_ff @(posedge clk) begin
        if (rst || burst_go) begin
            skip_q  <= '0;
            issue_q <= '0;
        end else if (accept) begin
            if (pair_zero) skip_q  <= skip_q + 1'b1;
            else           issue_q <= issue_q + 1'b1;
        end
    end

    assign skip_cnt  = skip_q;
    assign issue_cnt = issue_q;
`else
    assign skip_cnt  = '0;
    assign issue_cnt = '0;
`endif

endmodule
